rf_wb_queue: RTL and testbench
==============================

Name: rf_wb_queue

Overview:
- Write-side front end for the 32x32 register file: buffers writeback requests from multi-cycle producers (load unit, mul/div) and drains them, one per cycle, into the register file's single write port (W, W_Reg, W_data).
- Provides bypass lookup on the two decode read addresses, so readers see pending values before they reach the register file.
- Sits between the writeback stage and the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_n  in  1  asynchronous active-low reset.
- In_valid  in  1  producer has a write request.
- In_ready  out  1  queue can accept; equals !Full.
- In_Reg  in  5  destination register of the request.
- In_data  in  32  value to write.
- Stall  in  1  register file write port is busy; no drain this cycle.
- W  out  1  register-file write enable.
- W_Reg  out  5  register-file write address.
- W_data  out  32  register-file write data.
- R_Reg1, R_Reg2  in  5  read addresses from decode.
- Hit1, Hit2  out  1  a pending entry matches R_RegN.
- Fwd_data1, Fwd_data2  out  32  youngest pending value for R_RegN; 0 when no hit.
- Count  out  CW  occupied entries.
- Full, Empty  out  1  Count==DEPTH / Count==0.

Behaviour:
- Storage: circular buffer of {reg[4:0], data[31:0]} with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Count tracks occupancy explicitly.
- Reset (RST_n=0, asynchronous): head=tail=0, Count=0, Empty=1, Full=0, In_ready=1. All outputs follow combinationally: W=0, W_Reg=0, W_data=0, Hit1=Hit2=0, Fwd_data1=Fwd_data2=0. Reset mid-operation discards all pending entries; nothing is written to the register file.
- Push: In_valid & In_ready at posedge. If In_Reg==0, the request is accepted (handshake completes) but dropped, with no allocation. Otherwise the entry is written at tail, tail++, Count++.
- Drain (combinational outputs): W = !Empty & !Stall. W_Reg and W_data present the head entry when !Empty, else 0.
- Pop: at posedge when W=1, head++, Count--. The register file captures the entry on that same edge.
- Push latency: an entry pushed at edge t is visible on W/W_Reg/W_data and on the bypass outputs from cycle t+1. No same-cycle In→W or In→Fwd path.
- Simultaneous push and pop: both occur and Count is unchanged. When Full, In_ready=0 even if a pop happens that cycle (no full-cycle pass-through).
- Empty: W=0 regardless of Stall; pop never occurs.
- Stall held: the queue fills and Full asserts at Count==DEPTH. Producers must hold In_valid/In_reg/In_data until In_ready.
- Bypass: for each read port, scan the valid entries and select the youngest (closest to tail) with reg==R_RegN.
  - Hit=1 and Fwd_data = that entry's data.
  - R_RegN==0 always gives Hit=0, Fwd=0.
  - The head entry being popped this cycle still counts as a hit; the register file is updated at the same edge.
- Count never exceeds DEPTH and never underflows. In_ready=!Full is combinational from state only, not from In_valid.

Optional Feature:
- Macro RF_WBQ_COALESCE_EN.
- Defined: a push whose In_Reg matches a valid entry overwrites the youngest matching entry's data in place. No allocation; tail and Count are unchanged.
  - Exception: if the youngest match is the head and W=1 this cycle, a new entry is allocated normally.
  - In_ready remains !Full.
- Undefined: every nonzero push allocates a new entry, and duplicate registers drain in arrival order.

Test Plan:
- Reset then idle: RST_n low mid-cycle → W=0, Count=0, Empty=1, In_ready=1 immediately, with no CLK edge required.
- Push {R5,0x11111111} with Stall=0 → next cycle W=1, W_Reg=5, W_data=0x11111111; the cycle after, Empty=1, W=0.
- Stall=1, push R1..R4 (DEPTH=4) → Full=1, In_ready=0, and a fifth In_valid is not accepted. Release Stall → W_Reg sequence 1,2,3,4 on consecutive cycles, then Empty.
- Stall=1, push {R7,0xA}, {R7,0xB}; R_Reg1=7 → Hit1=1, Fwd_data1=0xB. Without the macro Count=2; with RF_WBQ_COALESCE_EN Count=1.
- Push {R0,0xDEAD} → handshake completes, Count stays 0, W never asserts. R_Reg2=0 → Hit2=0, Fwd_data2=0.
- Count=2 with Stall=0, then a simultaneous push of R9 → Count stays 2. Assert RST_n=0 while 2 entries are pending → queue empties and W drops to 0 without a clock edge.

Source files
------------

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback queue in front of the 32x32 register file.
// Buffers write requests from multi-cycle producers and drains them one per
// cycle into the register file's single write port. It also provides bypass
// lookup for the two decode read ports.
// Optional feature: define RF_WBQ_COALESCE_EN so that a push to a register
// that is already pending overwrites the youngest pending entry in place.
//
// Handshake (valid/ready): a request transfers on a posedge where
// In_valid && In_ready. In_ready depends only on internal state (== !Full).
// A producer holds In_valid/In_Reg/In_data stable until the transfer.
// The drain side has no ready signal. The register file takes the head entry
// on every posedge where W is high, and Stall suppresses W.
module rf_wb_queue #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [4:0]    In_Reg,
    input  logic [31:0]   In_data,
    input  logic          Stall,
    output logic          W,
    output logic [4:0]    W_Reg,
    output logic [31:0]   W_data,
    input  logic [4:0]    R_Reg1,
    input  logic [4:0]    R_Reg2,
    output logic          Hit1,
    output logic          Hit2,
    output logic [31:0]   Fwd_data1,
    output logic [31:0]   Fwd_data2,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Empty
);

    // Entry storage. Every entry at or beyond Count is treated as free, so
    // the arrays themselves need no reset.
    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic          push_hs;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] byp_idx;

    assign Empty    = (count_q == '0);
    assign Full     = (count_q == CW'(DEPTH));
    assign Count    = count_q;
    assign In_ready = !Full;

    assign W      = !Empty && !Stall;
    assign W_Reg  = Empty ? 5'd0  : reg_mem[head];
    assign W_data = Empty ? 32'd0 : data_mem[head];

    assign push_hs = In_valid && In_ready;
    assign pop     = W;

`ifdef RF_WBQ_COALESCE_EN
    logic          coal_found;
    logic [PW-1:0] coal_idx;
    logic [PW-1:0] coal_sel;

    // Find the youngest valid entry whose register matches the incoming request.
    always_comb begin
        coal_found = 1'b0;
        coal_sel   = '0;
        coal_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            coal_idx = head + PW'(k);
            if (CW'(k) < count_q && reg_mem[coal_idx] == In_Reg) begin
                coal_found = 1'b1;
                coal_sel   = coal_idx;
            end
        end
    end

    // A head entry that leaves this cycle cannot absorb the new value.
    assign coalesce = push_hs && (In_Reg != 5'd0) && coal_found &&
                      !((coal_sel == head) && pop);
    assign wr_idx   = coalesce ? coal_sel : tail;
`else
    assign coalesce = 1'b0;
    assign wr_idx   = tail;
`endif

    // Register 0 is never written, so a request to it completes the handshake without taking an entry.
    assign alloc = push_hs && (In_Reg != 5'd0) && !coalesce;
    assign wr_en = alloc || coalesce;

    // Pointer and occupancy update. A push and a pop in the same cycle leave Count unchanged.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (alloc) tail <= tail + PW'(1);
            if (pop)   head <= head + PW'(1);
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

    // Entry write. The write is either a new allocation at tail or an in-place merge.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            reg_mem[wr_idx]  <= In_Reg;
            data_mem[wr_idx] <= In_data;
        end
    end

    // Bypass: walk the entries from oldest to youngest so the youngest match wins.
    always_comb begin
        Hit1      = 1'b0;
        Hit2      = 1'b0;
        Fwd_data1 = 32'd0;
        Fwd_data2 = 32'd0;
        byp_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = head + PW'(k);
            if (CW'(k) < count_q) begin
                if (R_Reg1 != 5'd0 && reg_mem[byp_idx] == R_Reg1) begin
                    Hit1      = 1'b1;
                    Fwd_data1 = data_mem[byp_idx];
                end
                if (R_Reg2 != 5'd0 && reg_mem[byp_idx] == R_Reg2) begin
                    Hit2      = 1'b1;
                    Fwd_data2 = data_mem[byp_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed and random checks of rf_wb_queue against a queue model.
// Compile with RF_WBQ_COALESCE_EN to check the coalescing build.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          stall;
    logic          w;
    logic [4:0]    w_reg;
    logic [31:0]   w_data;
    logic [4:0]    r_reg1;
    logic [4:0]    r_reg2;
    logic          hit1;
    logic          hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    rf_wb_queue #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .RST_n(rst_n),
        .In_valid(in_valid), .In_ready(in_ready), .In_Reg(in_reg), .In_data(in_data),
        .Stall(stall), .W(w), .W_Reg(w_reg), .W_data(w_data),
        .R_Reg1(r_reg1), .R_Reg2(r_reg2), .Hit1(hit1), .Hit2(hit2),
        .Fwd_data1(fwd_data1), .Fwd_data2(fwd_data2),
        .Count(count), .Full(full), .Empty(empty)
    );

    // ---------------- scoreboard / model ----------------
    // Each entry is {reg[4:0], data[31:0]}, oldest at index 0.
    logic [36:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    bit last_hs;
    bit holding;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (r == 5'd0) return;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][36:32] == r) begin
                hit = 1'b1;
                d   = exp_q[i][31:0];
                return;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        int          n;
        logic        h1, h2, e_empty;
        logic [31:0] f1, f2;
        n       = exp_q.size();
        e_empty = (n == 0);
        lookup(r_reg1, h1, f1);
        lookup(r_reg2, h2, f2);
        chk({tag, "_count"}, 32'(count), 32'(n));
        chk({tag, "_empty"}, 32'(empty), 32'(e_empty));
        chk({tag, "_full"},  32'(full),  32'(n == DEPTH));
        chk({tag, "_ready"}, 32'(in_ready), 32'(n < DEPTH));
        chk({tag, "_w"},     32'(w), 32'(!e_empty && !stall));
        chk({tag, "_wreg"},  32'(w_reg), e_empty ? 32'd0 : 32'(exp_q[0][36:32]));
        chk({tag, "_wdata"}, w_data, e_empty ? 32'd0 : exp_q[0][31:0]);
        chk({tag, "_hit1"},  32'(hit1), 32'(h1));
        chk({tag, "_fwd1"},  fwd_data1, f1);
        chk({tag, "_hit2"},  32'(hit2), 32'(h2));
        chk({tag, "_fwd2"},  fwd_data2, f2);
    endtask

    // Apply the effect of the coming posedge to the model.
    task automatic model_edge(output bit hs);
        int          n;
        bit          pop_now;
        bit          merged;
        logic [36:0] tmp;
        n       = exp_q.size();
        pop_now = (n != 0) && !stall;
        merged  = 1'b0;
        hs      = in_valid && (n < DEPTH);
        if (hs && in_reg != 5'd0) begin
`ifdef RF_WBQ_COALESCE_EN
            for (int i = n - 1; i >= 0; i--) begin
                if (exp_q[i][36:32] == in_reg) begin
                    if (!(i == 0 && pop_now)) begin
                        tmp         = exp_q[i];
                        tmp[31:0]   = in_data;
                        exp_q[i]    = tmp;
                        merged      = 1'b1;
                    end
                    break;
                end
            end
`endif
            if (!merged) exp_q.push_back({in_reg, in_data});
        end
        if (pop_now) void'(exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag);
        bit hs;
        @(negedge clk);
        check_all(tag);
        model_edge(hs);
        last_hs = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d, input string tag);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            step(tag);
            if (last_hs) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_accepted"}, 32'(got), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        stall = 1'b0;
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) step(tag);
        chk({tag, "_drained"}, 32'(empty), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        in_valid = 1'b0;
        in_reg   = 5'd0;
        in_data  = 32'd0;
        stall    = 1'b0;
        r_reg1   = 5'd0;
        r_reg2   = 5'd0;
        holding  = 1'b0;

        // Reset asserted mid-cycle, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check_all("reset");
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push drains on the next cycle.
        push(5'd5, 32'h1111_1111, "t2_push");
        chk("t2_w", 32'(w), 32'd1);
        chk("t2_wreg", 32'(w_reg), 32'd5);
        chk("t2_wdata", w_data, 32'h1111_1111);
        step("t2_drain");
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_w_low", 32'(w), 32'd0);

        // Fill under stall, fifth request blocked, then drain in order.
        stall = 1'b1;
        for (int i = 1; i <= DEPTH; i++) push(5'(i), 32'h100 + 32'(i), "t3_fill");
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_reg   = 5'd6;
        in_data  = 32'h600;
        step("t3_fifth");
        chk("t3_fifth_count", 32'(count), 32'(DEPTH));
        in_valid = 1'b0;
        stall    = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("t3_order", 32'(w_reg), 32'(i));
            step("t3_drain");
        end
        chk("t3_empty", 32'(empty), 32'd1);

        // Duplicate register: youngest value forwarded.
        stall = 1'b1;
        push(5'd7, 32'hA, "t4_a");
        push(5'd7, 32'hB, "t4_b");
        r_reg1 = 5'd7;
        #1;
        chk("t4_hit1", 32'(hit1), 32'd1);
        chk("t4_fwd1", fwd_data1, 32'hB);
`ifdef RF_WBQ_COALESCE_EN
        chk("t4_count", 32'(count), 32'd1);
`else
        chk("t4_count", 32'(count), 32'd2);
`endif
        drain("t4");
        r_reg1 = 5'd0;

        // Register 0 request is accepted and dropped.
        push(5'd0, 32'hDEAD, "t5_r0");
        chk("t5_count", 32'(count), 32'd0);
        r_reg2 = 5'd0;
        step("t5_idle");
        chk("t5_w", 32'(w), 32'd0);
        chk("t5_hit2", 32'(hit2), 32'd0);
        chk("t5_fwd2", fwd_data2, 32'd0);

        // Simultaneous push and pop, then reset with entries pending.
        stall = 1'b1;
        push(5'd10, 32'hAAAA, "t6_a");
        push(5'd11, 32'hBBBB, "t6_b");
        stall    = 1'b0;
        in_valid = 1'b1;
        in_reg   = 5'd9;
        in_data  = 32'h9999;
        step("t6_pushpop");
        in_valid = 1'b0;
        chk("t6_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_w", 32'(w), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        check_all("t6_rst");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model; producers hold requests until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!holding) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_reg   = 5'($urandom_range(0, 7));
                in_data  = $urandom();
            end
            stall  = ($urandom_range(0, 99) < 35);
            r_reg1 = 5'($urandom_range(0, 7));
            r_reg2 = 5'($urandom_range(0, 7));
            step("rnd");
            holding = in_valid && !last_hs;
        end
        in_valid = 1'b0;
        drain("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
